pwm_generator_bank: RTL and testbench
=====================================

# pwm_generator_bank

Parametrised multi-generator PWM engine for the SPI-controlled peripheral. It replaces the fixed 4-generator / 8-output / 8-bit PWM block. Each generator has its own period, duty, prescaler and edge/center alignment, with shadow registers so updates are glitch-free. Outputs are routed through a per-pin crossbar with polarity control, and each generator emits a period-end strobe for the register file or interrupt logic.

## Interface
Clocking and reset (already decided): one clock, `clk`. Reset `rst` is asynchronous and active-high.

Parameters
- NUM_GEN, 4: number of PWM generators (≥2).
- NUM_OUT, 8: number of output pins.
- CNT_W, 8: counter, period and duty width.
- DIV_W, 4: prescaler exponent width.
- SEL_W, $clog2(NUM_GEN): per-output generator-select width.

Ports
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- gen_en  input  NUM_GEN  generator enable.
- gen_mode  input  NUM_GEN  0 = edge-aligned, 1 = center-aligned.
- gen_div  input  NUM_GEN*DIV_W  prescaler exponent d; generator g uses slice [g*DIV_W +: DIV_W].
- gen_top  input  NUM_GEN*CNT_W  period top value.
- gen_duty  input  NUM_GEN*CNT_W  duty compare value.
- out_en  input  NUM_OUT  pin enable / static level.
- out_pwm_en  input  NUM_OUT  pin drives PWM when this bit and out_en are both 1.
- out_sel  input  NUM_OUT*SEL_W  generator index per pin.
- out_inv  input  NUM_OUT  pin polarity invert.
- out  output  NUM_OUT  registered pin outputs.
- gen_period_end  output  NUM_GEN  one-cycle strobe per generator at each period boundary.

## Operation
- **Shadow registers.** Each generator keeps shadows top_s, duty_s, mode_s and div_s.
  - They load from the inputs every cycle while gen_en=0.
  - They load at each period boundary while gen_en=1.
  - Mid-period input changes are ignored.
- **Prescaler.** Counter width is 2^DIV_W−1 bits.
  - A tick occurs when presc == (1<<div_s)−1; presc then returns to 0, otherwise it increments.
  - div_s=0 gives a tick every clock.
- **Edge mode.**
  - On each tick, cnt wraps to 0 if cnt==top_s, otherwise cnt increments.
  - Period is (top_s+1) ticks.
  - The boundary is the tick with cnt==top_s.
- **Center mode.**
  - On each tick, cnt moves ±1 per dir.
  - When the next value equals top_s, dir becomes down. When the next value is 0, dir becomes up.
  - Period is 2*top_s ticks.
  - The boundary is any tick whose next cnt is 0.
  - top_s=0: cnt holds 0 and every tick is a boundary.
- **Compare.** pwm_raw[g] = gen_en[g] & (cnt < duty_s), unsigned CNT_W-bit comparison.
  - duty_s=0 gives constant 0.
  - duty_s>top_s gives constant 1.
- **Disable.** gen_en=0 forces cnt=0, presc=0, dir=up and gen_period_end=0.
- **Re-enable.** Counting restarts from cnt=0 using the shadows loaded while disabled.
- **Pin mux.**
  - If out_en[i] & out_pwm_en[i]: out[i] ← pwm_raw[out_sel[i]] ^ out_inv[i]. An out_sel value ≥ NUM_GEN selects 0.
  - Otherwise: out[i] ← out_en[i] ^ out_inv[i].
- **Simultaneous boundary and input change.** On a boundary, the input values present in that cycle are loaded.

## Timing
- **Reset values.**
  - cnt=0, presc=0, dir=up.
  - All shadows 0 (top 0, duty 0, edge mode, div 0).
  - out=0 and gen_period_end=0, regardless of out_inv.
- **Reset assertion** takes effect immediately (asynchronous), including mid-period. Outputs return to reset values.
- **Reset release.** The first clock after release loads the shadows (generators are treated as disabled until gen_en is sampled) and drives out to its static or PWM value.
- **Latency.**
  - pwm_raw is combinational from cnt and duty_s. out is registered, so a pin follows a cnt change by 1 cycle.
  - A change to out_en, out_pwm_en, out_sel or out_inv reaches out after 1 cycle.
- **gen_period_end[g]** is registered: high for exactly one cycle, the cycle in which cnt==0 following a boundary tick. The new shadows are active in that same cycle.
- **Steady state.** With div_s=d, period in clocks is (top_s+1)·2^d in edge mode and 2·top_s·2^d in center mode.

## Test plan
- **Edge waveform.** Gen0: edge, d=0, top=3, duty=2; pin0 out_sel=0 with out_en=out_pwm_en=1. Required: out[0] repeats 1,1,0,0 (period 4 clocks); gen_period_end[0] pulses every 4 clocks.
- **Center waveform.** Gen1: center, d=0, top=3, duty=2. Required: cnt runs 0,1,2,3,2,1; pin output repeats 1,1,0,0,0,1 (period 6 clocks).
- **Shadow update.** Gen0 edge, top=3; change duty 2→1 mid-period. Required: the old pattern finishes, then from the cycle gen_period_end pulses the pattern is 1,0,0,0.
- **Prescaler.** Gen0 edge, d=2, top=3, duty=2. Required: cnt advances every 4 clocks; out is high for 8 clocks and low for 8 clocks.
- **Limits and mux.**
  - duty=0 gives constant 0; duty=4 with top=3 gives constant 1.
  - out_inv=1 inverts the pin.
  - out_en=1, out_pwm_en=0 gives constant 1; out_en=0, out_inv=1 gives constant 1.
  - out_sel≥NUM_GEN gives 0^inv.
- **Reset mid-period.** Assert rst while cnt=2. Required: out=0 and gen_period_end=0 without waiting for a clock edge. After release with gen_en=1, the counter restarts at 0 and the first boundary occurs top_s+1 ticks later.

Source files
------------

// File: rtl/pwm_generator_bank.sv
// Bank of independent PWM generators with shadowed configuration, feeding a
// per-pin crossbar with polarity control and registered outputs.

module pwm_gen #(
  parameter int CNT_W = 8,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] top,
  input  logic [CNT_W-1:0] duty,
  output logic             pwm,
  output logic             period_end
);
  localparam int PW = (1 << DIV_W) - 1;

  typedef struct packed {
    logic [CNT_W-1:0] top;
    logic [CNT_W-1:0] duty;
    logic             mode;
    logic [DIV_W-1:0] div;
  } cfg_t;

  cfg_t             sh, cfg_in;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [PW-1:0]    presc, mask;
  logic             dir, dir_nxt;   // 1 = counting down
  logic             run, act, tick, bnd;

  assign cfg_in = {top, duty, mode, div};
  // run delays enable by a cycle so the first enabled clock only loads shadows
  assign act    = en & run;
  assign mask   = ~({PW{1'b1}} << sh.div);
  assign tick   = (presc == mask);

  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    bnd     = 1'b0;
    if (!sh.mode) begin
      bnd     = (cnt == sh.top);
      cnt_nxt = bnd ? '0 : cnt + CNT_W'(1);
      dir_nxt = 1'b0;
    end else if (sh.top == '0) begin
      bnd     = 1'b1;
      cnt_nxt = '0;
      dir_nxt = 1'b0;
    end else begin
      cnt_nxt = dir ? cnt - CNT_W'(1) : cnt + CNT_W'(1);
      bnd     = (cnt_nxt == '0);
      if (cnt_nxt == sh.top) dir_nxt = 1'b1;
      else if (bnd)          dir_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh         <= '0;
      cnt        <= '0;
      presc      <= '0;
      dir        <= 1'b0;
      run        <= 1'b0;
      period_end <= 1'b0;
    end else begin
      run <= en;
      if (!act) begin
        sh         <= cfg_in;
        cnt        <= '0;
        presc      <= '0;
        dir        <= 1'b0;
        period_end <= 1'b0;
      end else begin
        period_end <= tick & bnd;
        presc      <= tick ? '0 : presc + PW'(1);
        if (tick) begin
          cnt <= cnt_nxt;
          dir <= dir_nxt;
          if (bnd) sh <= cfg_in;
        end
      end
    end
  end

  assign pwm = en & (cnt < sh.duty);
endmodule

module pwm_generator_bank #(
  parameter int NUM_GEN = 4,
  parameter int NUM_OUT = 8,
  parameter int CNT_W   = 8,
  parameter int DIV_W   = 4,
  parameter int SEL_W   = $clog2(NUM_GEN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_GEN-1:0]       gen_en,
  input  logic [NUM_GEN-1:0]       gen_mode,
  input  logic [NUM_GEN*DIV_W-1:0] gen_div,
  input  logic [NUM_GEN*CNT_W-1:0] gen_top,
  input  logic [NUM_GEN*CNT_W-1:0] gen_duty,
  input  logic [NUM_OUT-1:0]       out_en,
  input  logic [NUM_OUT-1:0]       out_pwm_en,
  input  logic [NUM_OUT*SEL_W-1:0] out_sel,
  input  logic [NUM_OUT-1:0]       out_inv,
  output logic [NUM_OUT-1:0]       out,
  output logic [NUM_GEN-1:0]       gen_period_end
);
  localparam int NSEL = (1 << SEL_W) > NUM_GEN ? (1 << SEL_W) : NUM_GEN;

  logic [NUM_GEN-1:0] pwm_raw;
  logic [NSEL-1:0]    pwm_pad;
  logic [NUM_OUT-1:0] out_d;

  for (genvar g = 0; g < NUM_GEN; g++) begin : g_gen
    pwm_gen #(.CNT_W(CNT_W), .DIV_W(DIV_W)) u_gen (
      .clk        (clk),
      .rst        (rst),
      .en         (gen_en[g]),
      .mode       (gen_mode[g]),
      .div        (gen_div[g*DIV_W +: DIV_W]),
      .top        (gen_top[g*CNT_W +: CNT_W]),
      .duty       (gen_duty[g*CNT_W +: CNT_W]),
      .pwm        (pwm_raw[g]),
      .period_end (gen_period_end[g])
    );
  end

  // selects beyond the last generator read a zero
  always_comb begin
    pwm_pad              = '0;
    pwm_pad[NUM_GEN-1:0] = pwm_raw;
  end

  always_comb begin
    logic [SEL_W-1:0] sel;
    out_d = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      sel = out_sel[i*SEL_W +: SEL_W];
      if (out_en[i] & out_pwm_en[i]) out_d[i] = pwm_pad[sel] ^ out_inv[i];
      else                           out_d[i] = out_en[i] ^ out_inv[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= '0;
    else     out <= out_d;
  end
endmodule

// File: tb/tb_pwm_generator_bank.sv
// Scoreboarded bench for pwm_generator_bank: a phase-based reference model
// predicts every cycle, plus literal waveform checks anchored on period ends.

module tb_pwm_generator_bank;
  localparam int NG = 3, NO = 8, CW = 8, DW = 4, SW = $clog2(NG);

  logic clk = 1'b0, rst = 1'b0;
  logic [NG-1:0]    gen_en, gen_mode, gen_period_end;
  logic [NG*DW-1:0] gen_div;
  logic [NG*CW-1:0] gen_top, gen_duty;
  logic [NO-1:0]    out_en, out_pwm_en, out_inv, out;
  logic [NO*SW-1:0] out_sel;

  always #5 clk = ~clk;

  pwm_generator_bank #(.NUM_GEN(NG), .NUM_OUT(NO), .CNT_W(CW), .DIV_W(DW)) dut (
    .clk(clk), .rst(rst), .gen_en(gen_en), .gen_mode(gen_mode), .gen_div(gen_div),
    .gen_top(gen_top), .gen_duty(gen_duty), .out_en(out_en), .out_pwm_en(out_pwm_en),
    .out_sel(out_sel), .out_inv(out_inv), .out(out), .gen_period_end(gen_period_end)
  );

  int total = 0, bad = 0;
  string cur = "init";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference: position within period, cnt derived from it
  int             m_pos[NG], m_pc[NG];
  logic [CW-1:0]  m_top[NG], m_duty[NG];
  logic [DW-1:0]  m_div[NG];
  logic           m_mode[NG], m_run[NG];

  typedef struct packed { logic [NO-1:0] o; logic [NG-1:0] pe; } exp_t;
  exp_t sbq[$];

  task automatic model_reset();
    for (int g = 0; g < NG; g++) begin
      m_pos[g] = 0; m_pc[g] = 0; m_top[g] = '0; m_duty[g] = '0;
      m_div[g] = '0; m_mode[g] = 1'b0; m_run[g] = 1'b0;
    end
  endtask

  task automatic model_load(input int g);
    m_top[g]  = gen_top[g*CW +: CW];
    m_duty[g] = gen_duty[g*CW +: CW];
    m_mode[g] = gen_mode[g];
    m_div[g]  = gen_div[g*DW +: DW];
  endtask

  function automatic int mcnt(input int g);
    int t = int'(m_top[g]);
    if (!m_mode[g]) return m_pos[g];
    return (m_pos[g] <= t) ? m_pos[g] : 2 * t - m_pos[g];
  endfunction

  task automatic model_clk(output exp_t e);
    logic [NG-1:0] raw;
    int sel, len;
    bit tick, bnd;
    e = '0;
    for (int g = 0; g < NG; g++) raw[g] = gen_en[g] && (mcnt(g) < int'(m_duty[g]));
    for (int i = 0; i < NO; i++) begin
      sel = int'(out_sel[i*SW +: SW]);
      if (out_en[i] && out_pwm_en[i]) e.o[i] = ((sel < NG) ? raw[sel] : 1'b0) ^ out_inv[i];
      else                            e.o[i] = out_en[i] ^ out_inv[i];
    end
    if (rst) begin
      e = '0;
      model_reset();
    end else begin
      for (int g = 0; g < NG; g++) begin
        if (!(gen_en[g] && m_run[g])) begin
          m_pos[g] = 0; m_pc[g] = 0; model_load(g);
        end else begin
          tick = (m_pc[g] == (1 << m_div[g]) - 1);
          m_pc[g] = tick ? 0 : m_pc[g] + 1;
          if (tick) begin
            len = m_mode[g] ? ((m_top[g] == 0) ? 1 : 2 * int'(m_top[g])) : int'(m_top[g]) + 1;
            bnd = (m_pos[g] == len - 1);
            m_pos[g] = (m_pos[g] + 1) % len;
            e.pe[g] = bnd;
            if (bnd) model_load(g);
          end
        end
        m_run[g] = gen_en[g];
      end
    end
  endtask

  task automatic cyc();
    exp_t e, x;
    model_clk(e);
    sbq.push_back(e);
    @(posedge clk); #1;
    x = sbq.pop_front();
    chk({cur, ":out"}, 32'(out), 32'(x.o));
    chk({cur, ":pe"}, 32'(gen_period_end), 32'(x.pe));
  endtask

  task automatic wait_pe(input int g, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      cyc();
      if (gen_period_end[g]) ok = 1'b1;
    end
    if (!ok) chk({cur, ":timeout"}, 0, 1);
  endtask

  task automatic run_pat(input int g, input int pin, input logic [31:0] pat, input int len);
    bit ok;
    wait_pe(g, ok);
    if (ok)
      for (int k = 0; k < 2 * len; k++) begin
        if (k > 0) cyc();
        chk({cur, ":pat"}, 32'(out[pin]), 32'(pat[k % len]));
      end
  endtask

  task automatic const_chk(input int g, input int pin, input logic val, input int n);
    bit ok;
    wait_pe(g, ok);
    cyc();
    for (int k = 0; k < n; k++) begin
      chk({cur, ":const"}, 32'(out[pin]), 32'(val));
      cyc();
    end
  endtask

  task automatic set_gen(input int g, input logic en, input logic md, input int dv,
                         input int tp, input int dt);
    gen_en[g] = en; gen_mode[g] = md;
    gen_div[g*DW +: DW]  = DW'(dv);
    gen_top[g*CW +: CW]  = CW'(tp);
    gen_duty[g*CW +: CW] = CW'(dt);
  endtask

  task automatic set_pin(input int i, input logic en, input logic pw, input int sel, input logic inv);
    out_en[i] = en; out_pwm_en[i] = pw; out_inv[i] = inv;
    out_sel[i*SW +: SW] = SW'(sel);
  endtask

  initial begin
    bit ok;
    int n;
    gen_en = '0; gen_mode = '0; gen_div = '0; gen_top = '0; gen_duty = '0;
    out_en = '0; out_pwm_en = '0; out_sel = '0; out_inv = '1;
    model_reset();
    #1 rst = 1'b1;
    #2;
    cur = "reset";
    chk("reset:out", 32'(out), 0);
    chk("reset:pe", 32'(gen_period_end), 0);
    cyc(); cyc();

    out_inv = '0;
    set_gen(0, 1, 0, 0, 3, 2);
    set_pin(0, 1, 1, 0, 0);
    set_pin(1, 1, 0, 0, 0);
    set_pin(2, 0, 0, 0, 1);
    set_pin(3, 1, 1, 3, 1);
    set_pin(4, 1, 1, 0, 1);
    set_pin(5, 1, 1, 1, 0);
    rst = 1'b0;
    cur = "edge";
    cyc();
    chk("rel:p1", 32'(out[0]), 0);
    cyc();
    chk("rel:p2", 32'(out[0]), 1);
    chk("mux:static1", 32'(out[1]), 1);
    chk("mux:inv_off", 32'(out[2]), 1);
    chk("mux:selhi_inv", 32'(out[3]), 1);
    run_pat(0, 0, 32'b0110, 4);

    cur = "center";
    set_gen(1, 1, 1, 0, 3, 2);
    run_pat(1, 5, 32'b000111, 6);

    cur = "shadow";
    wait_pe(0, ok);
    cyc();
    set_gen(0, 1, 0, 0, 3, 1);
    run_pat(0, 0, 32'b0010, 4);

    cur = "presc";
    cyc();
    set_gen(0, 1, 0, 2, 3, 2);
    run_pat(0, 0, 32'h01FE, 16);

    cur = "duty0";
    set_gen(0, 1, 0, 0, 3, 0);
    const_chk(0, 0, 1'b0, 8);
    chk("duty0:inv_pin", 32'(out[4]), 1);
    cur = "duty4";
    set_gen(0, 1, 0, 0, 3, 4);
    const_chk(0, 0, 1'b1, 8);
    chk("duty4:inv_pin", 32'(out[4]), 0);

    cur = "selhi";
    set_pin(3, 1, 1, 3, 0);
    cyc();
    chk("selhi:noinv", 32'(out[3]), 0);

    cur = "rst_mid";
    set_gen(0, 1, 0, 0, 3, 2);
    wait_pe(0, ok);
    cyc(); cyc();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_mid:out", 32'(out), 0);
    chk("rst_mid:pe", 32'(gen_period_end), 0);
    cyc(); cyc();
    rst = 1'b0;
    ok = 1'b0; n = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      cyc();
      n++;
      if (gen_period_end[0]) ok = 1'b1;
    end
    chk("rst_mid:first_pe", n, 5);
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
